bresenham_line: RTL and testbench



---
 rtl/bresenham_line.sv | 164 ++++++++++++++++
 tb/tb_bresenham_line.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bresenham_line.sv
// Bresenham line-drawing engine: latches two endpoints on a start pulse,
// walks the integer path one pixel per accepted beat, emits on-screen pixels
// on a valid/ready stream, and pulses done after the last pixel.

package bresenham_pkg;
    typedef struct packed {
        shortint x;
        shortint y;
    } Point2D;
endpackage

`ifndef WIDTH
`define WIDTH 640
`endif
`ifndef HEIGHT
`define HEIGHT 480
`endif

module bresenham_line
    import bresenham_pkg::*;
(
    input  logic   clk,
    input  logic   n_rst,
    input  logic   start,
    input  Point2D p,
    input  Point2D q,
    output Point2D pixel,
    output logic   pixel_valid,
    input  logic   pixel_ready,
    output logic   busy,
    output logic   done
);

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

    localparam shortint MAX_X = 16'(`WIDTH - 1);
    localparam shortint MAX_Y = 16'(`HEIGHT - 1);

    state_t             state_reg, state_next;
    logic signed [15:0] x0_reg, x0_next, y0_reg, y0_next;
    logic signed [15:0] x1_reg, x1_next, y1_reg, y1_next;
    logic signed [16:0] dx_reg, dx_next, dy_reg, dy_next;
    logic               sx_neg_reg, sx_neg_next, sy_neg_reg, sy_neg_next;
    logic signed [17:0] err_reg, err_next;
    Point2D             cur_reg, cur_next;

    // Endpoint differences, widened by one bit so |x1-x0| never overflows.
    logic signed [16:0] diff_x, diff_y, abs_x, abs_y;
    assign diff_x = {x1_reg[15], x1_reg} - {x0_reg[15], x0_reg};
    assign diff_y = {y1_reg[15], y1_reg} - {y0_reg[15], y0_reg};
    assign abs_x  = diff_x[16] ? -diff_x : diff_x;
    assign abs_y  = diff_y[16] ? -diff_y : diff_y;

    // Error-term decisions for the current step; both use the old e2.
    logic signed [18:0] e2, dx_19, dy_19;
    logic signed [17:0] dx_18, dy_18, err_add_x, err_add_y;
    logic               step_x, step_y, on_screen, advance, at_end;
    assign e2        = {err_reg, 1'b0};
    assign dx_19     = {{2{dx_reg[16]}}, dx_reg};
    assign dy_19     = {{2{dy_reg[16]}}, dy_reg};
    assign dx_18     = {dx_reg[16], dx_reg};
    assign dy_18     = {dy_reg[16], dy_reg};
    assign step_x    = (e2 >= dy_19);
    assign step_y    = (e2 <= dx_19);
    assign err_add_x = step_x ? dy_18 : 18'sd0;
    assign err_add_y = step_y ? dx_18 : 18'sd0;

    assign on_screen = (cur_reg.x >= 16'sd0) && (cur_reg.x <= MAX_X) &&
                       (cur_reg.y >= 16'sd0) && (cur_reg.y <= MAX_Y);
    // Off-screen pixels are skipped without waiting for the consumer.
    assign advance   = !on_screen || pixel_ready;
    assign at_end    = (cur_reg.x == x1_reg) && (cur_reg.y == y1_reg);

    assign pixel = cur_reg;

    // State and datapath registers; reset abandons any line in progress.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg  <= IDLE;
            x0_reg     <= '0;
            y0_reg     <= '0;
            x1_reg     <= '0;
            y1_reg     <= '0;
            dx_reg     <= '0;
            dy_reg     <= '0;
            sx_neg_reg <= 1'b0;
            sy_neg_reg <= 1'b0;
            err_reg    <= '0;
            cur_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            x0_reg     <= x0_next;
            y0_reg     <= y0_next;
            x1_reg     <= x1_next;
            y1_reg     <= y1_next;
            dx_reg     <= dx_next;
            dy_reg     <= dy_next;
            sx_neg_reg <= sx_neg_next;
            sy_neg_reg <= sy_neg_next;
            err_reg    <= err_next;
            cur_reg    <= cur_next;
        end
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_next  = state_reg;
        x0_next     = x0_reg;
        y0_next     = y0_reg;
        x1_next     = x1_reg;
        y1_next     = y1_reg;
        dx_next     = dx_reg;
        dy_next     = dy_reg;
        sx_neg_next = sx_neg_reg;
        sy_neg_next = sy_neg_reg;
        err_next    = err_reg;
        cur_next    = cur_reg;
        pixel_valid = 1'b0;
        done        = 1'b0;
        busy        = (state_reg != IDLE);

        case (state_reg)
            IDLE: begin
                if (start) begin
                    x0_next    = p.x;
                    y0_next    = p.y;
                    x1_next    = q.x;
                    y1_next    = q.y;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                dx_next     = abs_x;
                dy_next     = -abs_y;
                sx_neg_next = !(x0_reg < x1_reg);
                sy_neg_next = !(y0_reg < y1_reg);
                err_next    = {abs_x[16], abs_x} - {abs_y[16], abs_y};
                cur_next.x  = x0_reg;
                cur_next.y  = y0_reg;
                state_next  = DRAW;
            end
            DRAW: begin
                pixel_valid = on_screen;
                if (advance) begin
                    if (at_end) begin
                        state_next = DONE;
                    end else begin
                        err_next = err_reg + err_add_x + err_add_y;
                        if (step_x)
                            cur_next.x = cur_reg.x + (sx_neg_reg ? 16'hFFFF : 16'h0001);
                        if (step_y)
                            cur_next.y = cur_reg.y + (sy_neg_reg ? 16'hFFFF : 16'h0001);
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bresenham_line.sv
// Scenario bench for bresenham_line: expected pixels and their cycle numbers
// go into a scoreboard queue; a monitor pops and compares each accepted beat.

module tb_bresenham_line;
    import bresenham_pkg::*;

    logic   clk = 1'b0;
    logic   n_rst;
    logic   start;
    Point2D p, q, pixel;
    logic   pixel_valid, pixel_ready, busy, done;

    bresenham_line dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .p          (p),
        .q          (q),
        .pixel      (pixel),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        Point2D pix;
        int     cyc;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    int     checks = 0;
    int     errors = 0;
    int     tick = 0;
    int     base = 0;
    logic   hist_valid[0:63];
    Point2D hist_pix[0:63];

    always @(posedge clk) tick <= tick + 1;

    function automatic Point2D pt(input int x, input int y);
        Point2D r;
        r.x = 16'(x);
        r.y = 16'(y);
        return r;
    endfunction

    // Scoreboard monitor: every accepted beat must match the head of the queue.
    always @(negedge clk) begin
        if (n_rst && pixel_valid && pixel_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra got (%0d,%0d) at cycle %0d, expected no pixel",
                         pixel.x, pixel.y, tick - base);
            end else begin
                mon_e = exp_q.pop_front();
                if (pixel !== mon_e.pix || (tick - base) !== mon_e.cyc) begin
                    errors++;
                    $display("FAIL sb_pixel got (%0d,%0d)@%0d, expected (%0d,%0d)@%0d",
                             pixel.x, pixel.y, tick - base,
                             mon_e.pix.x, mon_e.pix.y, mon_e.cyc);
                end
            end
        end
    end

    task automatic push(input int x, input int y, input int c);
        exp_t e;
        e.pix = pt(x, y);
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Drives one line: start in cycle 0, ready low in cycles flagged by low_mask,
    // an extra start pulse in cycle start2; records history until done or budget.
    task automatic run_line(input Point2D a, input Point2D b, input logic [31:0] low_mask,
                            input int start2, output int done_cyc, output int draw_cyc);
        done_cyc = -1;
        draw_cyc = 0;
        @(posedge clk); #1;
        p = a; q = b; start = 1'b1; pixel_ready = !low_mask[0];
        base = tick;
        for (int k = 1; k < 48; k++) begin
            @(posedge clk); #1;
            start = (k == start2);
            p = pt(100, 100);
            q = pt(200, 50);
            pixel_ready = (k < 32) ? !low_mask[k] : 1'b1;
            @(negedge clk);
            hist_valid[k] = pixel_valid;
            hist_pix[k]   = pixel;
            if (busy && !done && k >= 2) draw_cyc++;
            if (done) begin
                checks++;
                if (pixel_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL done_with_valid pixel_valid=%b, expected 0", pixel_valid);
                end
                done_cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        n_rst = 1'b0; start = 1'b0; pixel_ready = 1'b0; p = pt(0, 0); q = pt(0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({pixel_valid, busy, done} !== 3'b000 || pixel !== pt(0, 0)) begin
            errors++;
            $display("FAIL reset_state got valid/busy/done=%b pixel=(%0d,%0d), expected 000 (0,0)",
                     {pixel_valid, busy, done}, pixel.x, pixel.y);
        end
        @(posedge clk); #1;
        n_rst = 1'b1;
    endtask

    task automatic test_horizontal;
        int d, dr;
        for (int i = 0; i < 4; i++) push(i, 0, 2 + i);
        run_line(pt(0, 0), pt(3, 0), 32'd0, -1, d, dr);
        checks++;
        if (d !== 6) begin errors++; $display("FAIL horiz_done got cycle %0d, expected 6", d); end
        checks++;
        if (dr !== 4) begin errors++; $display("FAIL horiz_draw got %0d cycles, expected 4", dr); end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL horiz_missing got %0d unsent pixels, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL horiz_idle busy=%b, expected 0", busy); end
    endtask

    task automatic test_steep;
        int d, dr;
        push(0, 0, 2); push(0, 1, 3); push(1, 2, 4); push(1, 3, 5);
        run_line(pt(0, 0), pt(1, 3), 32'd0, -1, d, dr);
        checks++;
        if (d !== 6) begin errors++; $display("FAIL steep_done got cycle %0d, expected 6", d); end
    endtask

    // Starts in the cycle right after the previous done.
    task automatic test_back_to_back;
        int d, dr;
        push(5, 5, 2); push(4, 4, 3); push(3, 3, 4); push(2, 2, 5);
        run_line(pt(5, 5), pt(2, 2), 32'd0, -1, d, dr);
        checks++;
        if (d !== 6) begin errors++; $display("FAIL reverse_done got cycle %0d, expected 6", d); end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL reverse_missing got %0d unsent pixels, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_point;
        int d, dr;
        push(7, 9, 2);
        run_line(pt(7, 9), pt(7, 9), 32'd0, 2, d, dr);
        checks++;
        if (d !== 3) begin errors++; $display("FAIL point_done got cycle %0d, expected 3", d); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL point_ignored_start busy=%b done=%b, expected 0 0", busy, done);
            end
        end
    endtask

    task automatic test_backpressure;
        int d, dr;
        push(0, 0, 5); push(1, 0, 6); push(2, 0, 7);
        run_line(pt(0, 0), pt(2, 0), 32'b11100, -1, d, dr);
        checks++;
        if (d !== 8) begin errors++; $display("FAIL stall_done got cycle %0d, expected 8", d); end
        for (int k = 2; k <= 4; k++) begin
            checks++;
            if (hist_valid[k] !== 1'b1 || hist_pix[k] !== pt(0, 0)) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got valid=%b (%0d,%0d), expected 1 (0,0)",
                         k, hist_valid[k], hist_pix[k].x, hist_pix[k].y);
            end
        end
    endtask

    task automatic test_clipping;
        int d, dr;
        push(0, 0, 4); push(1, 0, 5);
        run_line(pt(-2, 0), pt(1, 0), 32'd0, -1, d, dr);
        checks++;
        if (d !== 6) begin errors++; $display("FAIL clip_done got cycle %0d, expected 6", d); end
        checks++;
        if (dr !== 4) begin errors++; $display("FAIL clip_draw got %0d cycles, expected 4", dr); end
        checks++;
        if (hist_valid[2] !== 1'b0 || hist_valid[3] !== 1'b0) begin
            errors++;
            $display("FAIL clip_offscreen got valid %b%b, expected 00", hist_valid[2], hist_valid[3]);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL clip_missing got %0d unsent pixels, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid;
        int d, dr, done_seen;
        done_seen = 0;
        push(0, 0, 2); push(1, 0, 3);
        @(posedge clk); #1;
        p = pt(0, 0); q = pt(10, 0); start = 1'b1; pixel_ready = 1'b1;
        base = tick;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        checks++;
        if ({pixel_valid, busy, done} !== 3'b000 || pixel !== pt(0, 0)) begin
            errors++;
            $display("FAIL midreset_async got valid/busy/done=%b pixel=(%0d,%0d), expected 000 (0,0)",
                     {pixel_valid, busy, done}, pixel.x, pixel.y);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL midreset_pixels got %0d unsent pixels, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++; $display("FAIL midreset_done got %0d done pulses, expected 0", done_seen);
        end
        for (int i = 0; i < 3; i++) push(i, 0, 2 + i);
        run_line(pt(0, 0), pt(2, 0), 32'd0, -1, d, dr);
        checks++;
        if (d !== 5) begin errors++; $display("FAIL midreset_redraw got done cycle %0d, expected 5", d); end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_steep();
        test_back_to_back();
        test_point();
        test_backpressure();
        test_clipping();
        test_reset_mid();
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL final_queue got %0d unsent pixels, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
